// File: rtl/decoder.sv
// rtl/decoder.sv - ReduxV opcode to control-word decoder with writable table
module decoder #(
  parameter int SIZE = 16,
  parameter int WORD = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      opcode,
  input  logic            we,
  input  logic [3:0]      waddr,
  input  logic [WORD-1:0] wdata,
  output logic [3:0]      ulasrc,
  output logic [2:0]      pcsrc,
  output logic            imm,
  output logic            regsrc,
  output logic            mw,
  output logic            rw
);

  logic [WORD-1:0] rom [0:SIZE-1];
  logic [WORD-1:0] word;

  // Built-in control words, packed {ulasrc, pcsrc, imm, regsrc, mw, rw}
  function automatic logic [WORD-1:0] default_word(input logic [3:0] op);
    logic [WORD-1:0] w;
    case (op)
      4'd0:    w = 11'h090;
      4'd1:    w = 11'h0A8;
      4'd2:    w = 11'h030;
      4'd3:    w = 11'h048;
      4'd4:    w = 11'h405;
      4'd5:    w = 11'h402;
      4'd6:    w = 11'h489;
      4'd7:    w = 11'h509;
      4'd8:    w = 11'h001;
      4'd9:    w = 11'h081;
      4'd10:   w = 11'h101;
      4'd11:   w = 11'h181;
      4'd12:   w = 11'h201;
      4'd13:   w = 11'h281;
      4'd14:   w = 11'h301;
      default: w = 11'h381;
    endcase
    return w;
  endfunction

  // Reset reloads the whole table and takes priority over a write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        rom[i] <= default_word(4'(i));
      end
    end else if (we) begin
      rom[waddr] <= wdata;
    end
  end

  assign word   = rom[opcode];
  assign ulasrc = word[10:7];
  assign pcsrc  = word[6:4];
  assign imm    = word[3];
  assign regsrc = word[2];
  assign mw     = word[1];
  assign rw     = word[0];

endmodule

// File: tb/tb_decoder.sv
// tb/tb_decoder.sv - directed self-checking bench for decoder
module tb_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        we;
  logic [3:0]  waddr;
  logic [10:0] wdata;
  logic [3:0]  ulasrc;
  logic [2:0]  pcsrc;
  logic        imm;
  logic        regsrc;
  logic        mw;
  logic        rw;

  int checks_total;
  int checks_passed;

  logic [10:0] defaults [0:15];
  logic [10:0] preload  [0:15];

  decoder dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .ulasrc (ulasrc),
    .pcsrc  (pcsrc),
    .imm    (imm),
    .regsrc (regsrc),
    .mw     (mw),
    .rw     (rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %03h, expected %03h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {ulasrc, pcsrc, imm, regsrc, mw, rw};
  endfunction

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    defaults = '{11'h090, 11'h0A8, 11'h030, 11'h048, 11'h405, 11'h402, 11'h489, 11'h509,
                 11'h001, 11'h081, 11'h101, 11'h181, 11'h201, 11'h281, 11'h301, 11'h381};
    rst    = 1'b0;
    we     = 1'b0;
    waddr  = 4'd0;
    wdata  = 11'h000;
    opcode = 4'd0;

    // Hierarchical preload at time 0 without reset
    for (int i = 0; i < 16; i++) begin
      preload[i] = 11'h7FF ^ 11'(i * 11'h045);
      dut.rom[i] = preload[i];
    end
    for (int i = 0; i < 16; i++) begin
      opcode = 4'(i);
      #1;
      check($sformatf("preload op%0d", i), outs(), preload[i]);
    end
    opcode = 4'd0;
    #1;
    check("preload 7FF ulasrc", {7'd0, ulasrc}, 11'h00F);
    check("preload 7FF pcsrc", {8'd0, pcsrc}, 11'h007);

    // Reset then combinational sweep of the default table
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      opcode = 4'(i);
      #1;
      check($sformatf("default op%0d", i), outs(), defaults[i]);
    end
    opcode = 4'd4;
    #1;
    check("op4 ulasrc", {7'd0, ulasrc}, 11'h008);
    check("op4 regsrc/rw", {9'd0, regsrc, rw}, 11'h003);
    opcode = 4'd3;
    #1;
    check("op3 pcsrc", {8'd0, pcsrc}, 11'h004);
    check("op3 imm/rw", {9'd0, imm, rw}, 11'h002);

    // Single write to entry 8
    @(posedge clk);
    #1;
    we = 1'b1; waddr = 4'd8; wdata = 11'h2A5;
    @(posedge clk);
    #1 we = 1'b0;
    opcode = 4'd8;
    #1;
    check("write op8", outs(), 11'h2A5);
    check("write op8 ulasrc", {7'd0, ulasrc}, 11'h005);
    check("write op8 pcsrc", {8'd0, pcsrc}, 11'h002);
    opcode = 4'd9;
    #1;
    check("write op9 untouched", outs(), 11'h081);

    // Same-cycle read and write of entry 2
    opcode = 4'd2; we = 1'b1; waddr = 4'd2; wdata = 11'h7FF;
    #1;
    check("rw same before edge", outs(), 11'h030);
    @(posedge clk);
    #1;
    check("rw same after edge", outs(), 11'h7FF);
    we = 1'b0;

    // Reset wins over a simultaneous write
    opcode = 4'd0; we = 1'b1; waddr = 4'd0; wdata = 11'h7FF; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0;
    check("rst over write op0", outs(), 11'h090);
    opcode = 4'd2;
    #1;
    check("rst restores op2", outs(), 11'h030);
    opcode = 4'd8;
    #1;
    check("rst restores op8", outs(), 11'h001);

    // Overwrite entry 5 then reset restores it
    opcode = 4'd5; we = 1'b1; waddr = 4'd5; wdata = 11'h000;
    @(posedge clk);
    #1 we = 1'b0;
    check("op5 zeroed", outs(), 11'h000);
    pulse_reset();
    check("op5 after reset", outs(), 11'h402);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
